uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter for the communication subsystem. Serialises one frame per accepted word with:
- compile-time data width
- per-frame runtime selection of parity (none/even/odd) and stop bits (1 or 2)
- valid/ready handshake, so an upstream FIFO or packetiser can stream frames back-to-back without software polling.

It feeds the board TX pin directly and replaces the fixed 8N1 transmitter in new designs.

## Interface
- BAUD, 9600: line rate in bit/s
- CLK_F, 50_000_000: clock frequency in Hz; CLKS_PER_BIT = CLK_F/BAUD (integer division), must be ≥ 2 (elaboration-time assertion)
- DATA_W, 8: data bits per frame, legal 5..9 (elaboration-time assertion)
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- i_tx_data  in  DATA_W  word to send, LSB first
- i_valid  in  1  word/config valid
- o_ready  out  1  block can accept; transfer occurs on a rising edge with i_valid & o_ready
- i_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
- i_two_stop  in  1  1 = two stop bits
- o_tx_serial  out  1  serial line, idle high
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse at frame completion
- o_state  out  3  current FSM state (debug)

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_ready=1, line high. On accept:
  - capture data, parity mode and stop count into registers
  - compute the parity bit: even = ^data, odd = ~^data
  - state→START
- Later input changes have no effect on a frame in flight.
- START: line 0 for CLKS_PER_BIT cycles → DATA.
- DATA: line = data[bit_idx], bit_idx 0..DATA_W-1, each bit CLKS_PER_BIT cycles. After the last bit → PARITY if parity enabled, else STOP.
- PARITY: line = captured parity bit for CLKS_PER_BIT cycles → STOP.
- STOP: line 1 for CLKS_PER_BIT cycles, or 2×CLKS_PER_BIT if two stop bits. On the final period end: o_done=1, o_busy=0, state→IDLE.
- Bit-period counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1. Compare with zero-extended operands; no truncation warnings.
- Stop-bit counter: 1 bit.
- Illegal state encoding → IDLE with the reset values.

## Timing
- Reset values: o_tx_serial=1, o_ready=1, o_busy=0, o_done=0, o_state=IDLE; all counters and registers 0.
- Reset mid-frame aborts immediately: line returns high asynchronously and no o_done is issued.
- All outputs are registered.
- Accept at edge k:
  - o_tx_serial=0, o_busy=1, o_ready=0 from after edge k.
  - Start bit occupies cycles k+1 .. k+CLKS_PER_BIT.
- Frame length L = CLKS_PER_BIT × (1 + DATA_W + P + S), with P ∈ {0,1} and S ∈ {1,2}.
- At edge k+L: o_done=1 for exactly one cycle, o_busy=0, o_ready=1, line high.
- Back-to-back: with i_valid held, the next accept occurs at edge k+L+1. Exactly one idle-high clock separates frames, and the next start bit begins after edge k+L+1.
- i_valid while o_ready=0 is ignored. The block does not latch it; the upstream must hold it.
- o_done and a new accept never coincide (accept requires IDLE, which starts one cycle later).

## Structure
- Package uart_pkg:
  - state enum (3-bit, IDLE=0)
  - parity enum (NONE=2'b00, EVEN=2'b01, ODD=2'b10)
  - function clks_per_bit(CLK_F, BAUD)
  - shared by the future matching receiver
- Sub-module uart_bit_timer:
  - bit-period counter with inputs clear/enable and a registered o_tick on the last count
  - parameter CLKS_PER_BIT
  - reused by the RX
- The top holds the FSM, shift/index logic, parity and handshake.

## Test plan
All scenarios use CLK_F=1_000_000, BAUD=100_000 (10 clk/bit).
- Reset: rst_n low mid-DATA of frame 0xA5 → line high within the reset, o_busy=0, no o_done, o_ready=1 after release.
- 8N1, data 0x55: line shows 0,1,0,1,0,1,0,1,0,1, each 10 cycles. o_done pulses at accept+100, one cycle.
- 8E2, data 0x07 (odd count of ones): parity bit 1, 20 stop cycles, L=120. 8O1, data 0x07: parity bit 0, L=110.
- DATA_W=5 instance, 5N1, data 5'h1F: L=70; upper bits absent.
- i_valid held for three words 0x01,0x02,0x03: o_ready handshakes at 0, 101, 202. Exactly one idle-high cycle between stop and next start. The words are received intact by a reference UART monitor.
- Change i_tx_data and i_parity mid-frame: the transmitted frame is unchanged; i_valid during busy is not accepted until o_ready.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the future matching receiver.
// Holds the FSM state and parity encodings, plus the bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } uart_parity_e;

  function automatic int clks_per_bit(input int clk_f, input int baud);
    return clk_f / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: o_tick is registered and is high during the last clock of each period.
// Latency: the first tick appears CLKS_PER_BIT-1 enabled edges after i_clr; no backpressure.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // The tick is raised one edge early so the consumer acts exactly on the period boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end
    tick_d = i_en && !i_clr && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with per-frame parity/stop selection; line goes low the edge after accept.
// Backpressure: o_ready is high only in IDLE, so a held i_valid is taken one clock after o_done.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int BAUD   = 9600,
  parameter int CLK_F  = 50_000_000,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_parity,
  input  logic              i_two_stop,
  output logic              o_tx_serial,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_F, BAUD);
  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  // State held as a plain 3-bit vector so unused encodings stay representable and recoverable.
  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_PARITY = ST_PARITY;
  localparam logic [2:0] S_STOP   = ST_STOP;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLK_F/BAUD must be at least 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
    $error("uart_tx_frame: DATA_W must be within 5..9");
  end

  logic [2:0]        state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              two_stop_q, two_stop_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              accept;
  logic              tick;

  assign accept = i_valid && ready_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (accept),
    .i_en   (busy_q),
    .o_tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    data_d     = data_q;
    idx_d      = idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (accept) begin
          data_d     = i_tx_data;
          par_en_d   = (i_parity == PAR_EVEN) || (i_parity == PAR_ODD);
          par_bit_d  = (i_parity == PAR_ODD) ? ~^i_tx_data : ^i_tx_data;
          two_stop_d = i_two_stop;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = data_q[0];
          data_d  = data_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_d  = idx_q + IDX_ONE;
            tx_d   = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = S_IDLE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            ready_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        ready_d    = 1'b1;
        data_d     = '0;
        idx_d      = '0;
        par_en_d   = 1'b0;
        par_bit_d  = 1'b0;
        two_stop_d = 1'b0;
        stop_cnt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign o_tx_serial = tx_q;
  assign o_busy      = busy_q;
  assign o_ready     = ready_q;
  assign o_done      = done_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at 10 clocks per bit, with an 8-bit and a 5-bit instance.
// Expected line patterns are hand-built vectors: bit 0 is the start slot, stop slots at the top.
module tb_uart_tx_frame;

  localparam int CLK_F = 1_000_000;
  localparam int BAUD  = 100_000;
  localparam int C     = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] d8 = '0;
  logic       v8 = 1'b0, ts8 = 1'b0;
  logic [1:0] p8 = '0;
  logic       tx8, rdy8, busy8, done8;
  logic [2:0] st8;

  logic [4:0] d5 = '0;
  logic       v5 = 1'b0, ts5 = 1'b0;
  logic [1:0] p5 = '0;
  logic       tx5, rdy5, busy5, done5;
  logic [2:0] st5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.BAUD(BAUD), .CLK_F(CLK_F), .DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_tx_data(d8), .i_valid(v8), .o_ready(rdy8),
    .i_parity(p8), .i_two_stop(ts8), .o_tx_serial(tx8), .o_busy(busy8),
    .o_done(done8), .o_state(st8)
  );

  uart_tx_frame #(.BAUD(BAUD), .CLK_F(CLK_F), .DATA_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .i_tx_data(d5), .i_valid(v5), .o_ready(rdy5),
    .i_parity(p5), .i_two_stop(ts5), .o_tx_serial(tx5), .o_busy(busy5),
    .o_done(done5), .o_state(st5)
  );

  // Handshake log for the 8-bit instance, in clock-edge numbers.
  always @(posedge clk) begin
    if (rst_n && v8 && rdy8) acc_q.push_back(cyc);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after the accept edge; returns #1 after the completion edge.
  task automatic check_frame(input bit sel5, input logic [11:0] bits, input int nb,
                             input string tag);
    int bad = 0;
    int early = 0;
    logic tx, bsy, rdy, dn;
    logic [2:0] st;
    for (int c = 0; c < nb * C; c++) begin
      tx  = sel5 ? tx5 : tx8;
      bsy = sel5 ? busy5 : busy8;
      rdy = sel5 ? rdy5 : rdy8;
      dn  = sel5 ? done5 : done8;
      if (tx !== bits[c / C] || bsy !== 1'b1 || rdy !== 1'b0) bad++;
      if (dn !== 1'b0) early++;
      step(1);
    end
    tx  = sel5 ? tx5 : tx8;
    bsy = sel5 ? busy5 : busy8;
    rdy = sel5 ? rdy5 : rdy8;
    dn  = sel5 ? done5 : done8;
    st  = sel5 ? st5 : st8;
    chk({tag, "_wave_bad_cycles"}, bad, 0);
    chk({tag, "_early_done"}, early, 0);
    chk({tag, "_done_at_L"}, dn, 1);
    chk({tag, "_busy_at_L"}, bsy, 0);
    chk({tag, "_ready_at_L"}, rdy, 1);
    chk({tag, "_line_at_L"}, tx, 1);
    chk({tag, "_state_at_L"}, st, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int base;
    int bad;
    #12;
    chk("rst_line", tx8, 1);
    chk("rst_ready", rdy8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_state", st8, 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // 8N1 0x55
    d8 = 8'h55; p8 = 2'b00; ts8 = 1'b0; v8 = 1'b1;
    step(1);
    v8 = 1'b0;
    chk("8n1_accept_ready", rdy8, 0);
    check_frame(1'b0, 12'h2AA, 10, "8n1_55");
    step(1);
    chk("8n1_done_one_cycle", done8, 0);

    // 8E2 0x07: three ones -> even parity bit 1
    d8 = 8'h07; p8 = 2'b01; ts8 = 1'b1; v8 = 1'b1;
    step(1);
    v8 = 1'b0;
    check_frame(1'b0, 12'hE0E, 12, "8e2_07");
    step(1);

    // 8O1 0x07 -> odd parity bit 0
    d8 = 8'h07; p8 = 2'b10; ts8 = 1'b0; v8 = 1'b1;
    step(1);
    v8 = 1'b0;
    check_frame(1'b0, 12'h40E, 11, "8o1_07");
    step(1);

    // 5N1 0x1F on the narrow instance; parity code 11 means none
    d5 = 5'h1F; p5 = 2'b11; ts5 = 1'b0; v5 = 1'b1;
    step(1);
    v5 = 1'b0;
    check_frame(1'b1, 12'h07E, 7, "5n1_1f");
    step(1);
    chk("5n1_done_one_cycle", done5, 0);

    // Back-to-back with i_valid held
    base = acc_q.size();
    d8 = 8'h01; p8 = 2'b00; ts8 = 1'b0; v8 = 1'b1;
    step(1);
    d8 = 8'h02;
    check_frame(1'b0, 12'h202, 10, "b2b_01");
    step(1);
    d8 = 8'h03;
    check_frame(1'b0, 12'h204, 10, "b2b_02");
    step(1);
    v8 = 1'b0;
    check_frame(1'b0, 12'h206, 10, "b2b_03");
    step(1);
    chk("b2b_accepts", acc_q.size() - base, 3);
    if (acc_q.size() - base >= 3) begin
      chk("b2b_gap1", acc_q[base + 1] - acc_q[base], 101);
      chk("b2b_gap2", acc_q[base + 2] - acc_q[base + 1], 101);
    end

    // Inputs change mid-frame; 0xC3 has four ones -> odd parity bit 1
    base = acc_q.size();
    d8 = 8'hC3; p8 = 2'b10; ts8 = 1'b0; v8 = 1'b1;
    step(1);
    v8 = 1'b0;
    fork
      check_frame(1'b0, 12'h786, 11, "midchg_c3");
      begin
        step(30);
        d8 = 8'h3C; p8 = 2'b00; ts8 = 1'b1; v8 = 1'b1;
      end
    join
    step(1);
    v8 = 1'b0;
    check_frame(1'b0, 12'h678, 11, "held_3c");
    step(1);
    chk("midchg_accepts", acc_q.size() - base, 2);
    if (acc_q.size() - base >= 2) chk("midchg_gap", acc_q[base + 1] - acc_q[base], 111);

    // Reset in the middle of data bit 3 of 0xA5 (that bit is 0)
    d8 = 8'hA5; p8 = 2'b00; ts8 = 1'b0; v8 = 1'b1;
    step(1);
    v8 = 1'b0;
    step(44);
    chk("rst_mid_line_before", tx8, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line", tx8, 1);
    chk("rst_mid_busy", busy8, 0);
    chk("rst_mid_done", done8, 0);
    step(3);
    rst_n = 1'b1;
    chk("rst_mid_ready", rdy8, 1);
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      if (done8 !== 1'b0 || tx8 !== 1'b1 || busy8 !== 1'b0) bad++;
      step(1);
    end
    chk("rst_mid_quiet_after", bad, 0);
    chk("rst_mid_state", st8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
